mem_bus_adapter: RTL and testbench
==================================

MEM_BUS_ADAPTER -- requirements
Module: mem_bus_adapter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the max REQ-state cycles without busAck before abort (range 1..255).
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port address  in  32  byte address from datapath.
REQ-005 SHALL have port writeData  in  32  store data, right-aligned.
REQ-006 SHALL have port readReq  in  1  load request.
REQ-007 SHALL have port writeEnable  in  1  store request.
REQ-008 SHALL have port readLen  in  2  load size: 0 byte, 1 half, 2 word, 3 treated as word.
REQ-009 SHALL have port writeLen  in  2  store size, same encoding.
REQ-010 SHALL have port readSignExtend  in  1  sign-extend byte/half loads when 1, else zero-extend.
REQ-011 SHALL have port dataOut  out  32  registered, aligned, extended load result.
REQ-012 SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-013 SHALL have port done  out  1  one-cycle completion pulse.
REQ-014 SHALL have port busError  out  1  registered; set with done on timeout.
REQ-015 SHALL have port misaligned  out  1  registered; set with done on a trapped access.
REQ-016 SHALL have ports busAddr out 30 (word address = address[31:2]), busWData out 32, busByteEn out 4, busWe out 1, busReq out 1.
REQ-017 SHALL have ports busAck in 1 and busRData in 32.

Function
REQ-018 SHALL implement states IDLE, REQ, FINISH.
REQ-019 In IDLE, SHALL accept a request on a rising edge where readReq or writeEnable is high; writeEnable has priority when both are high.
REQ-020 On accept, SHALL register busAddr, busWData, busByteEn, busWe, size, offset and sign mode; set busReq=1; go to REQ.
REQ-021 Bus outputs SHALL hold stable while busReq=1.
REQ-022 In REQ, at an edge with busAck=1: SHALL drop busReq, capture aligned load data into dataOut (reads only), and go to FINISH.
REQ-023 In FINISH, done=1 for exactly one cycle; the next state is IDLE. Minimum latency: accept at edge 0, busReq high in cycle 1, and with busAck in cycle 1, done is high in cycle 2.
REQ-024 busAck while busReq=0 SHALL be ignored.
REQ-025 The timeout counter SHALL clear on accept and increment each REQ cycle without ack. On reaching TIMEOUT_CYCLES: drop busReq, set busError=1, go to FINISH, leave dataOut unchanged.
REQ-026 busError and misaligned SHALL clear on the next accept.
REQ-027 Store lanes:
- byte: writeData[7:0] replicated to all 4 lanes; busByteEn = 1 << address[1:0].
- half: writeData[15:0] replicated; busByteEn = 4'b0011 if address[1]=0, else 4'b1100.
- word: busByteEn = 4'b1111.
REQ-028 Reads SHALL drive busByteEn=4'b1111 and busWe=0.
REQ-029 Load extraction:
- byte: lane address[1:0] of busRData.
- half: upper half if address[1]=1, else lower half.
- word: busRData unchanged.
- Result extended per readSignExtend.
REQ-030 Requests arriving while busy SHALL be ignored (not queued).

Reset
REQ-031 Reset SHALL immediately force state IDLE; busReq, busWe, done, busError, misaligned, busy = 0; busByteEn=0; busAddr, busWData, dataOut = 0; timeout counter = 0.
REQ-032 Reset asserted mid-REQ SHALL drop busReq in the same cycle, without waiting for a clock edge; a late busAck after release SHALL be ignored.

Configuration
REQ-033 Macro MISALIGN_TRAP_EN:
- Defined: a half access with address[0]=1, or a word access with address[1:0]!=0, SHALL start no bus cycle (busReq stays 0) and SHALL go to FINISH with misaligned=1 and done=1 one cycle after accept.
- Undefined: misaligned is tied 0; half ignores address[0], word ignores address[1:0] (silent align-down).

Verification
REQ-034 Load byte at 0x1003, signExt=1, busRData=0x80FFFFFF, ack in cycle 1 -> busByteEn=4'b1111, busWe=0, dataOut=0xFFFFFF80, done high in cycle 2.
REQ-035 Store half at 0x2002, writeData=0x0000BEEF -> busAddr=0x800, busWData=0xBEEFBEEF, busByteEn=4'b1100, busWe=1; with ack delayed 3 cycles, done arrives 1 cycle after ack.
REQ-036 TIMEOUT_CYCLES=4, read with no ack -> busReq high exactly 4 cycles, then done=1 with busError=1; dataOut unchanged.
REQ-037 Reset asserted in cycle 2 of a pending read -> busReq=0 immediately; busAck=1 after release produces no done pulse.
REQ-038 Word load at 0x3001 -> with MISALIGN_TRAP_EN: busReq never rises, done=1 and misaligned=1 one cycle after accept; without: busAddr=0xC00, dataOut=busRData, misaligned=0.

Source files
------------

// File: rtl/mem_bus_adapter_if.sv
// Word-addressed memory bus between mem_bus_adapter (master) and a memory or fabric (slave).
interface mem_bus_adapter_if;
  logic [29:0] busAddr;
  logic [31:0] busWData;
  logic [3:0]  busByteEn;
  logic        busWe;
  logic        busReq;
  logic        busAck;
  logic [31:0] busRData;

  modport master (
    output busAddr, busWData, busByteEn, busWe, busReq,
    input  busAck, busRData
  );

  modport slave (
    input  busAddr, busWData, busByteEn, busWe, busReq,
    output busAck, busRData
  );
endinterface

// File: rtl/mem_bus_adapter.sv
// Datapath-to-word-bus load/store adapter with byte lanes, load extension and request timeout.
// Optional `MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of aligning them down.
module mem_bus_adapter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        address,
  input  logic [31:0]        writeData,
  input  logic               readReq,
  input  logic               writeEnable,
  input  logic [1:0]         readLen,
  input  logic [1:0]         writeLen,
  input  logic               readSignExtend,
  output logic [31:0]        dataOut,
  output logic               busy,
  output logic               done,
  output logic               busError,
  output logic               misaligned,
  mem_bus_adapter_if.master  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

  // Length code 3 behaves as a full word.
  function automatic size_e norm_size(input logic [1:0] len);
    size_e sz;
    case (len)
      2'd0:    sz = SZ_BYTE;
      2'd1:    sz = SZ_HALF;
      default: sz = SZ_WORD;
    endcase
    return sz;
  endfunction

  function automatic logic [31:0] store_lanes(input size_e sz, input logic [31:0] wd);
    logic [31:0] lanes;
    case (sz)
      SZ_BYTE: lanes = {4{wd[7:0]}};
      SZ_HALF: lanes = {2{wd[15:0]}};
      default: lanes = wd;
    endcase
    return lanes;
  endfunction

  function automatic logic [3:0] store_byte_en(input size_e sz, input logic [1:0] off);
    logic [3:0] be;
    case (sz)
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] load_extract(input size_e sz, input logic [1:0] off,
                                               input logic [31:0] rdata, input logic sext);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] res;
    lane_b = rdata[{off, 3'b000} +: 8];
    lane_h = off[1] ? rdata[31:16] : rdata[15:0];
    case (sz)
      SZ_BYTE: res = {{24{sext & lane_b[7]}}, lane_b};
      SZ_HALF: res = {{16{sext & lane_h[15]}}, lane_h};
      default: res = rdata;
    endcase
    return res;
  endfunction

`ifdef MISALIGN_TRAP_EN
  function automatic logic is_misaligned(input size_e sz, input logic [1:0] off);
    logic bad;
    case (sz)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      default: bad = (off != 2'b00);
    endcase
    return bad;
  endfunction
`endif

  state_e      state_q, state_d;
  logic [29:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic        bus_we_q, bus_we_d;
  logic        bus_req_q, bus_req_d;
  size_e       size_q, size_d;
  logic [1:0]  offset_q, offset_d;
  logic        sext_q, sext_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic [31:0] data_out_q, data_out_d;
  logic        bus_error_q, bus_error_d;
  logic        misaligned_q, misaligned_d;

  logic        acc_wr_s;
  size_e       acc_size_s;
  logic        trap_s;
  logic [7:0]  tmo_next_s;

  // Next-state and register-input logic of the request FSM.
  always_comb begin
    state_d      = state_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_be_d     = bus_be_q;
    bus_we_d     = bus_we_q;
    bus_req_d    = bus_req_q;
    size_d       = size_q;
    offset_d     = offset_q;
    sext_d       = sext_q;
    tmo_cnt_d    = tmo_cnt_q;
    data_out_d   = data_out_q;
    bus_error_d  = bus_error_q;
    misaligned_d = misaligned_q;

    acc_wr_s   = writeEnable;
    acc_size_s = norm_size(writeEnable ? writeLen : readLen);
    tmo_next_s = tmo_cnt_q + 8'd1;
`ifdef MISALIGN_TRAP_EN
    trap_s = is_misaligned(acc_size_s, address[1:0]);
`else
    trap_s = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (readReq || writeEnable) begin
          bus_addr_d   = address[31:2];
          bus_wdata_d  = acc_wr_s ? store_lanes(acc_size_s, writeData) : 32'd0;
          bus_be_d     = acc_wr_s ? store_byte_en(acc_size_s, address[1:0]) : 4'b1111;
          bus_we_d     = acc_wr_s;
          size_d       = acc_size_s;
          offset_d     = address[1:0];
          sext_d       = readSignExtend & ~acc_wr_s;
          tmo_cnt_d    = 8'd0;
          bus_error_d  = 1'b0;
          misaligned_d = trap_s;
          if (trap_s) begin
            // Trapped access never reaches the bus.
            bus_req_d = 1'b0;
            state_d   = ST_FINISH;
          end else begin
            bus_req_d = 1'b1;
            state_d   = ST_REQ;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus.busAck) begin
          bus_req_d = 1'b0;
          if (!bus_we_q) begin
            data_out_d = load_extract(size_q, offset_q, bus.busRData, sext_q);
          end else begin
            data_out_d = data_out_q;
          end
          state_d = ST_FINISH;
        end else if (tmo_next_s == TMO_LIMIT) begin
          tmo_cnt_d   = tmo_next_s;
          bus_req_d   = 1'b0;
          bus_error_d = 1'b1;
          state_d     = ST_FINISH;
        end else begin
          tmo_cnt_d = tmo_next_s;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        bus_req_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything, bus request included.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      bus_addr_q   <= 30'd0;
      bus_wdata_q  <= 32'd0;
      bus_be_q     <= 4'd0;
      bus_we_q     <= 1'b0;
      bus_req_q    <= 1'b0;
      size_q       <= SZ_BYTE;
      offset_q     <= 2'd0;
      sext_q       <= 1'b0;
      tmo_cnt_q    <= 8'd0;
      data_out_q   <= 32'd0;
      bus_error_q  <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_be_q     <= bus_be_d;
      bus_we_q     <= bus_we_d;
      bus_req_q    <= bus_req_d;
      size_q       <= size_d;
      offset_q     <= offset_d;
      sext_q       <= sext_d;
      tmo_cnt_q    <= tmo_cnt_d;
      data_out_q   <= data_out_d;
      bus_error_q  <= bus_error_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign bus.busAddr   = bus_addr_q;
  assign bus.busWData  = bus_wdata_q;
  assign bus.busByteEn = bus_be_q;
  assign bus.busWe     = bus_we_q;
  assign bus.busReq    = bus_req_q;

  assign dataOut    = data_out_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_FINISH);
  assign busError   = bus_error_q;
  assign misaligned = misaligned_q;

endmodule

// File: tb/tb_mem_bus_adapter.sv
// Randomized load/store bench for mem_bus_adapter against a byte-level reference model.
module tb_mem_bus_adapter;
  localparam int TMO = 4;

  logic        clk;
  logic        reset;
  logic [31:0] address;
  logic [31:0] writeData;
  logic        readReq;
  logic        writeEnable;
  logic [1:0]  readLen;
  logic [1:0]  writeLen;
  logic        readSignExtend;
  logic [31:0] dataOut;
  logic        busy;
  logic        done;
  logic        busError;
  logic        misaligned;

  mem_bus_adapter_if bus_if ();

  mem_bus_adapter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk            (clk),
    .reset          (reset),
    .address        (address),
    .writeData      (writeData),
    .readReq        (readReq),
    .writeEnable    (writeEnable),
    .readLen        (readLen),
    .writeLen       (writeLen),
    .readSignExtend (readSignExtend),
    .dataOut        (dataOut),
    .busy           (busy),
    .done           (done),
    .busError       (busError),
    .misaligned     (misaligned),
    .bus            (bus_if)
  );

  int checks;
  int failures;
  logic [31:0] exp_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int size_bytes(input logic [1:0] len);
    return (len == 2'd0) ? 1 : ((len == 2'd1) ? 2 : 4);
  endfunction

  // Reference load: shift the addressed bytes down, mask, then extend.
  function automatic logic [31:0] ref_load(input logic [1:0] len, input int off,
                                           input logic [31:0] rdata, input bit sext);
    int sz;
    int base;
    logic [31:0] v;
    sz = size_bytes(len);
    if (sz == 4) return rdata;
    base = (sz == 1) ? off : (off / 2) * 2;
    v = rdata >> (8 * base);
    if (sz == 1) begin
      v = v & 32'h0000_00FF;
      if (sext && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else begin
      v = v & 32'h0000_FFFF;
      if (sext && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // One transaction, entered and left on a falling edge.
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] len, input bit sext, input int ack_dly,
                         input logic [31:0] rdata);
    int sz, off, endc;
    bit trap, tmo;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    sz  = size_bytes(len);
    off = int'(addr[1:0]);
    trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap = (sz == 2 && (off % 2) != 0) || (sz == 4 && off != 0);
`endif
    if (!wr)          begin e_be = 4'hF; e_wd = 32'd0; end
    else if (sz == 1) begin e_be = 4'(1 << off); e_wd = (wd & 32'hFF) * 32'h0101_0101; end
    else if (sz == 2) begin e_be = (off >= 2) ? 4'hC : 4'h3; e_wd = (wd & 32'hFFFF) * 32'h0001_0001; end
    else              begin e_be = 4'hF; e_wd = wd; end
    tmo  = !trap && (ack_dly >= TMO);
    endc = trap ? 1 : (tmo ? TMO + 1 : ack_dly + 2);

    address = addr; writeData = wd; readLen = len; writeLen = len;
    readSignExtend = sext; writeEnable = wr;
    readReq = wr ? 1'($urandom % 2) : 1'b1;
    @(negedge clk);
    for (int c = 1; c <= endc; c++) begin
      if (c < endc) begin
        check_eq("busReq_hi", 32'(bus_if.busReq), 32'd1);
        check_eq("busAddr", 32'(bus_if.busAddr), addr >> 2);
        check_eq("busByteEn", 32'(bus_if.busByteEn), 32'(e_be));
        check_eq("busWe", 32'(bus_if.busWe), 32'(wr));
        if (wr) check_eq("busWData", bus_if.busWData, e_wd);
        check_eq("done_lo", 32'(done), 32'd0);
        check_eq("busy_req", 32'(busy), 32'd1);
        // Requests made while busy must be dropped.
        readReq = 1'($urandom % 2); writeEnable = 1'($urandom % 2); address = $urandom;
        bus_if.busAck   = (c == ack_dly + 1);
        bus_if.busRData = (c == ack_dly + 1) ? rdata : $urandom;
      end else begin
        if (!trap && !tmo && !wr) exp_data = ref_load(len, off, rdata, sext);
        check_eq("done_hi", 32'(done), 32'd1);
        check_eq("busReq_lo", 32'(bus_if.busReq), 32'd0);
        check_eq("busError", 32'(busError), 32'(tmo));
        check_eq("misaligned", 32'(misaligned), 32'(trap));
        check_eq("dataOut", dataOut, exp_data);
        readReq = 1'b0; writeEnable = 1'b0;
        bus_if.busAck   = 1'($urandom % 2);
        bus_if.busRData = $urandom;
      end
      @(negedge clk);
    end
    check_eq("done_once", 32'(done), 32'd0);
    check_eq("idle", 32'(busy), 32'd0);
    check_eq("dataOut_hold", dataOut, exp_data);
    check_eq("busError_hold", 32'(busError), 32'(tmo));
    bus_if.busAck = 1'b0;
  endtask

  initial begin
    logic [31:0] prev;
    checks = 0; failures = 0; exp_data = 32'd0;
    reset = 1'b0; address = 32'd0; writeData = 32'd0; readReq = 1'b0; writeEnable = 1'b0;
    readLen = 2'd0; writeLen = 2'd0; readSignExtend = 1'b0;
    bus_if.busAck = 1'b0; bus_if.busRData = 32'd0;
    #2 reset = 1'b1;
    #1;
    check_eq("rst_busReq", 32'(bus_if.busReq), 32'd0);
    check_eq("rst_busByteEn", 32'(bus_if.busByteEn), 32'd0);
    check_eq("rst_busAddr", 32'(bus_if.busAddr), 32'd0);
    check_eq("rst_dataOut", dataOut, 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Signed byte load from the top lane.
    run_txn(1'b0, 32'h0000_1003, 32'd0, 2'd0, 1'b1, 0, 32'h80FF_FFFF);
    check_eq("ldb_data", dataOut, 32'hFFFF_FF80);
    check_eq("ldb_be", 32'(bus_if.busByteEn), 32'hF);
    check_eq("ldb_we", 32'(bus_if.busWe), 32'd0);

    // Upper half store with delayed ack.
    run_txn(1'b1, 32'h0000_2002, 32'h0000_BEEF, 2'd1, 1'b0, 3, 32'd0);
    check_eq("sth_addr", 32'(bus_if.busAddr), 32'h800);
    check_eq("sth_wdata", bus_if.busWData, 32'hBEEF_BEEF);
    check_eq("sth_be", 32'(bus_if.busByteEn), 32'hC);
    check_eq("sth_we", 32'(bus_if.busWe), 32'd1);

    // Read with no ack times out and keeps old load data.
    prev = dataOut;
    run_txn(1'b0, 32'h0000_5000, 32'd0, 2'd2, 1'b0, TMO + 3, 32'h1234_5678);
    check_eq("tmo_data", dataOut, prev);

    // Unaligned word load.
    run_txn(1'b0, 32'h0000_3001, 32'd0, 2'd2, 1'b0, 1, 32'hCAFE_F00D);
    check_eq("ldw_addr", 32'(bus_if.busAddr), 32'hC00);
`ifndef MISALIGN_TRAP_EN
    check_eq("ldw_data", dataOut, 32'hCAFE_F00D);
`endif

    for (int i = 0; i < 80; i++) begin
      run_txn(1'($urandom % 2), $urandom, $urandom, 2'($urandom % 4), 1'($urandom % 2),
              int'($urandom_range(0, TMO + 1)), $urandom);
    end

    // Reset in the middle of a pending read.
    address = 32'h0000_4000; readLen = 2'd2; readReq = 1'b1;
    @(negedge clk);
    readReq = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("midrst_busReq", 32'(bus_if.busReq), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_dataOut", dataOut, 32'd0);
    exp_data = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    bus_if.busAck = 1'b1; bus_if.busRData = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("late_ack_done", 32'(done), 32'd0);
      check_eq("late_ack_busy", 32'(busy), 32'd0);
    end
    bus_if.busAck = 1'b0;
    check_eq("late_ack_data", dataOut, exp_data);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
